// File: rtl/reg_view_pkg.sv
// Shared definitions for the register view scheduler: FSM encoding, index width,
// step-request kinds and modulo index arithmetic.
package reg_view_pkg;

    localparam int IDX_W         = 5;
    localparam int START_REG_DEF = 5;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_NEXT = 2'd1,
        STEP_PREV = 2'd2,
        STEP_AUTO = 2'd3
    } step_e;

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx, input int num_regs);
        logic [IDX_W-1:0] res;
        if (int'(idx) >= num_regs - 1) begin
            res = '0;
        end else begin
            res = idx + 5'd1;
        end
        return res;
    endfunction

    function automatic logic [IDX_W-1:0] idx_dec(input logic [IDX_W-1:0] idx, input int num_regs);
        logic [IDX_W-1:0] res;
        if (idx == 5'd0) begin
            res = IDX_W'(num_regs - 1);
        end else begin
            res = idx - 5'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/reg_view_scheduler_btn_sync_edge.sv
// Two-flop synchronizer for a raw button followed by a registered
// single-cycle pulse on each rising edge.
module btn_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    logic [1:0] sync_r;
    logic       last_r;
    logic       pulse_r;

    // synchronize the button and emit one pulse per rising edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r  <= 2'b00;
            last_r  <= 1'b0;
            pulse_r <= 1'b0;
        end else begin
            sync_r  <= {sync_r[0], btn};
            last_r  <= sync_r[1];
            pulse_r <= sync_r[1] & ~last_r;
        end
    end

    assign pulse = pulse_r;

endmodule

// File: rtl/reg_view_scheduler.sv
// Register view scheduler: chooses which register to show, reads it through the
// register-file debug port and latches a stable snapshot for the display.
module reg_view_scheduler
    import reg_view_pkg::*;
#(
    parameter int NUM_REGS  = 32,
    parameter int RD_LAT    = 1,
    parameter int DWELL     = 200,
    parameter int START_REG = START_REG_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              btn_next,
    input  logic              btn_prev,
    input  logic              auto_en,
    input  logic              freeze,
    output logic [IDX_W-1:0]  rd_addr,
    input  logic [31:0]       rd_data,
    output logic [31:0]       disp_value,
    output logic [IDX_W-1:0]  disp_index,
    output logic              disp_valid
);

    localparam int                DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0]   DWELL_LAST = DW_W'(DWELL - 1);
    localparam logic [1:0]        LAT_LAST   = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;
    localparam logic [IDX_W-1:0]  START_IDX  = IDX_W'(START_REG);

    logic [1:0]       state_r;
    logic [1:0]       wait_cnt_r;
    logic [DW_W-1:0]  dwell_r;
    logic [IDX_W-1:0] rd_addr_r;
    logic [IDX_W-1:0] disp_index_r;
    logic [31:0]      disp_value_r;
    logic             disp_valid_r;
    logic             pend_next_r;
    logic             pend_prev_r;

    logic             next_pulse_s;
    logic             prev_pulse_s;
    logic             btn_en_s;
    logic             next_ev_s;
    logic             prev_ev_s;
    logic             start_rd_s;
    step_e            step_s;
    logic [IDX_W-1:0] next_idx_s;

    btn_sync_edge u_sync_next (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_next),
        .pulse (next_pulse_s)
    );

    btn_sync_edge u_sync_prev (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_prev),
        .pulse (prev_pulse_s)
    );

    // qualify button pulses and arbitrate the single step request for this cycle
    always_comb begin
        btn_en_s  = ~auto_en & ~freeze;
        next_ev_s = next_pulse_s & btn_en_s;
        prev_ev_s = prev_pulse_s & btn_en_s;
        step_s    = STEP_NONE;
        if ((state_r == ST_IDLE) && !freeze) begin
            if (next_ev_s || pend_next_r) begin
                step_s = STEP_NEXT;
            end else if (prev_ev_s || pend_prev_r) begin
                step_s = STEP_PREV;
            end else if (auto_en && tick && (dwell_r == DWELL_LAST)) begin
                step_s = STEP_AUTO;
            end else begin
                step_s = STEP_NONE;
            end
        end else begin
            step_s = STEP_NONE;
        end
        start_rd_s = (state_r == ST_IDLE) && !freeze && ((step_s != STEP_NONE) || tick);
    end

    // index that the next read will target
    always_comb begin
        next_idx_s = rd_addr_r;
        case (step_s)
            STEP_NEXT, STEP_AUTO: next_idx_s = idx_inc(rd_addr_r, NUM_REGS);
            STEP_PREV:            next_idx_s = idx_dec(rd_addr_r, NUM_REGS);
            default:              next_idx_s = rd_addr_r;
        endcase
    end

    // read sequencer: issue address, wait out the read latency, capture snapshot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            wait_cnt_r   <= 2'd0;
            rd_addr_r    <= START_IDX;
            disp_index_r <= START_IDX;
            disp_value_r <= 32'd0;
            disp_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_rd_s) begin
                        rd_addr_r  <= next_idx_s;
                        wait_cnt_r <= 2'd0;
                        state_r    <= (RD_LAT == 0) ? ST_CAPTURE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_r == LAT_LAST) begin
                        state_r <= ST_CAPTURE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 2'd1;
                    end
                end
                ST_CAPTURE: begin
                    disp_value_r <= rd_data;
                    disp_index_r <= rd_addr_r;
                    disp_valid_r <= 1'b1;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // one-deep pending request per direction while a read is in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_next_r <= 1'b0;
            pend_prev_r <= 1'b0;
        end else if (step_s != STEP_NONE) begin
            pend_next_r <= 1'b0;
            pend_prev_r <= 1'b0;
        end else if (state_r != ST_IDLE) begin
            pend_next_r <= pend_next_r | next_ev_s;
            pend_prev_r <= pend_prev_r | prev_ev_s;
        end
    end

    // dwell counter for automatic scanning; only counts ticks seen while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_r <= '0;
        end else if (!auto_en || (step_s == STEP_AUTO)) begin
            dwell_r <= '0;
        end else if (tick && !freeze && (state_r == ST_IDLE)) begin
            dwell_r <= dwell_r + DW_W'(1);
        end
    end

    assign rd_addr    = rd_addr_r;
    assign disp_value = disp_value_r;
    assign disp_index = disp_index_r;
    assign disp_valid = disp_valid_r;

endmodule

// File: tb/tb_reg_view_scheduler.sv
// Scoreboard bench for reg_view_scheduler: a 32-register instance with one-cycle
// read latency and a small 8-register instance with zero read latency.
module tb_reg_view_scheduler;

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick_a, btn_next_a, btn_prev_a, auto_en_a, freeze_a;
    logic [4:0]  rd_addr_a, disp_index_a;
    logic [31:0] rd_data_a, disp_value_a, base_a;
    logic        disp_valid_a;
    logic        tick_b, btn_next_b, btn_prev_b, auto_en_b, freeze_b;
    logic [4:0]  rd_addr_b, disp_index_b;
    logic [31:0] rd_data_b, disp_value_b;
    logic        disp_valid_b;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    always #5 clk = ~clk;

    reg_view_scheduler #(.NUM_REGS(32), .RD_LAT(1), .DWELL(4), .START_REG(5)) dut_a (
        .clk(clk), .rst_n(rst_n), .tick(tick_a), .btn_next(btn_next_a), .btn_prev(btn_prev_a),
        .auto_en(auto_en_a), .freeze(freeze_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .disp_value(disp_value_a), .disp_index(disp_index_a), .disp_valid(disp_valid_a)
    );

    reg_view_scheduler #(.NUM_REGS(8), .RD_LAT(0), .DWELL(2), .START_REG(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .tick(tick_b), .btn_next(btn_next_b), .btn_prev(btn_prev_b),
        .auto_en(auto_en_b), .freeze(freeze_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .disp_value(disp_value_b), .disp_index(disp_index_b), .disp_valid(disp_valid_b)
    );

    // register file models: one-cycle registered read for A, combinational for B
    always @(posedge clk) rd_data_a <= base_a + {27'd0, rd_addr_a};
    assign rd_data_b = 32'h200 + {27'd0, rd_addr_b};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_a(input logic [4:0] i, input logic [31:0] v);
        exp_t e;
        e.idx = i;
        e.val = v;
        q_a.push_back(e);
    endtask

    task automatic push_b(input logic [4:0] i, input logic [31:0] v);
        exp_t e;
        e.idx = i;
        e.val = v;
        q_b.push_back(e);
    endtask

    // monitors: every new snapshot shown on a display is matched against its queue
    logic        seen_a = 1'b0, seen_b = 1'b0;
    logic [36:0] last_a, last_b;
    exp_t        e_a, e_b;

    always @(negedge clk) begin
        if (!rst_n) begin
            seen_a = 1'b0;
        end else if (disp_valid_a && (!seen_a || ({disp_index_a, disp_value_a} != last_a))) begin
            seen_a = 1'b1;
            last_a = {disp_index_a, disp_value_a};
            if (q_a.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL a_unexpected: idx %0d val 0x%0h shown, no update expected", disp_index_a, disp_value_a);
            end else begin
                e_a = q_a.pop_front();
                check("a_idx", {27'd0, disp_index_a}, {27'd0, e_a.idx});
                check("a_val", disp_value_a, e_a.val);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            seen_b = 1'b0;
        end else if (disp_valid_b && (!seen_b || ({disp_index_b, disp_value_b} != last_b))) begin
            seen_b = 1'b1;
            last_b = {disp_index_b, disp_value_b};
            if (q_b.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL b_unexpected: idx %0d val 0x%0h shown, no update expected", disp_index_b, disp_value_b);
            end else begin
                e_b = q_b.pop_front();
                check("b_idx", {27'd0, disp_index_b}, {27'd0, e_b.idx});
                check("b_val", disp_value_b, e_b.val);
            end
        end
    end

    task automatic drain(input int budget);
        int k = 0;
        while (((q_a.size() != 0) || (q_b.size() != 0)) && (k < budget)) begin
            @(posedge clk);
            k++;
        end
        n_tests++;
        if ((q_a.size() != 0) || (q_b.size() != 0)) begin
            n_fail++;
            $display("FAIL drain: a=%0d b=%0d expected updates missing after %0d cycles, need 0", q_a.size(), q_b.size(), budget);
            q_a.delete();
            q_b.delete();
        end
        repeat (8) @(posedge clk);
    endtask

    task automatic press(input logic nxt_a, input logic prv_a, input logic nxt_b);
        @(posedge clk); #1;
        btn_next_a = nxt_a;
        btn_prev_a = prv_a;
        btn_next_b = nxt_b;
        repeat (3) @(posedge clk); #1;
        btn_next_a = 1'b0;
        btn_prev_a = 1'b0;
        btn_next_b = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic pulse_tick_a();
        @(posedge clk); #1 tick_a = 1'b1;
        @(posedge clk); #1 tick_a = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst_n = 1'b0;
        base_a = 32'h100;
        {tick_a, btn_next_a, btn_prev_a, auto_en_a, freeze_a} = 5'b00000;
        {tick_b, btn_next_b, btn_prev_b, auto_en_b, freeze_b} = 5'b00000;
        repeat (3) @(posedge clk); #1;
        check("rst_rd_addr", {27'd0, rd_addr_a}, 32'd5);
        check("rst_disp_index", {27'd0, disp_index_a}, 32'd5);
        check("rst_disp_value", disp_value_a, 32'd0);
        check("rst_disp_valid", {31'd0, disp_valid_a}, 32'd0);
        rst_n = 1'b1;

        // first refresh on A: snapshot lands RD_LAT+2 = 3 edges after the tick
        push_a(5'd5, 32'h105);
        pulse_tick_a();
        check("tick_rd_addr", {27'd0, rd_addr_a}, 32'd5);
        @(posedge clk); #1;
        check("lat_early_valid", {31'd0, disp_valid_a}, 32'd0);
        @(posedge clk); #1;
        check("lat_value", disp_value_a, 32'h105);
        check("lat_index", {27'd0, disp_index_a}, 32'd5);
        check("lat_valid", {31'd0, disp_valid_a}, 32'd1);
        drain(20);

        // B: zero read latency, snapshot 2 edges after the tick
        push_b(5'd5, 32'h205);
        @(posedge clk); #1 tick_b = 1'b1;
        @(posedge clk); #1 tick_b = 1'b0;
        check("b_lat_early_valid", {31'd0, disp_valid_b}, 32'd0);
        @(posedge clk); #1;
        check("b_lat_value", disp_value_b, 32'h205);
        drain(20);

        // B wraps at NUM_REGS=8
        push_b(5'd6, 32'h206); press(1'b0, 1'b0, 1'b1); drain(40);
        push_b(5'd7, 32'h207); press(1'b0, 1'b0, 1'b1); drain(40);
        push_b(5'd0, 32'h200); press(1'b0, 1'b0, 1'b1); drain(40);

        // A manual stepping: up to 8, down to 0, wrap below 0 and above 31
        for (int i = 6; i <= 8; i++) begin
            push_a(5'(i), 32'h100 + 32'(i));
            press(1'b1, 1'b0, 1'b0);
            drain(40);
        end
        for (int i = 7; i >= 0; i--) begin
            push_a(5'(i), 32'h100 + 32'(i));
            press(1'b0, 1'b1, 1'b0);
            drain(40);
        end
        push_a(5'd31, 32'h11F); press(1'b0, 1'b1, 1'b0); drain(40);
        push_a(5'd0, 32'h100);  press(1'b1, 1'b0, 1'b0); drain(40);

        // next and prev together: only +1
        push_a(5'd1, 32'h101); press(1'b1, 1'b1, 1'b0); drain(40);
        check("collide_idx", {27'd0, disp_index_a}, 32'd1);

        // next pulse lands while a refresh read is in WAIT: serviced afterwards
        push_a(5'd2, 32'h102);
        @(posedge clk); #1 btn_next_a = 1'b1;
        @(posedge clk);
        @(posedge clk); #1 tick_a = 1'b1;
        @(posedge clk); #1 tick_a = 1'b0;
        repeat (2) @(posedge clk); #1 btn_next_a = 1'b0;
        drain(40);

        // two next pulses around an in-flight read: only +1
        push_a(5'd3, 32'h103);
        @(posedge clk); #1 btn_next_a = 1'b1;
        @(posedge clk); #1 btn_next_a = 1'b0;
        @(posedge clk); #1 begin btn_next_a = 1'b1; tick_a = 1'b1; end
        @(posedge clk); #1 tick_a = 1'b0;
        repeat (3) @(posedge clk); #1 btn_next_a = 1'b0;
        drain(40);
        check("double_idx", {27'd0, disp_index_a}, 32'd3);

        // auto scan with DWELL=4: 12 ticks give exactly 3 steps
        auto_en_a = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            if ((t % 4) == 0) push_a(5'(3 + t / 4), 32'h103 + 32'(t / 4));
            pulse_tick_a();
            repeat (5) @(posedge clk);
        end
        drain(40);
        check("auto_idx", {27'd0, disp_index_a}, 32'd6);

        // dropping auto_en mid-dwell clears the count
        for (int t = 0; t < 2; t++) begin pulse_tick_a(); repeat (5) @(posedge clk); end
        #1 auto_en_a = 1'b0;
        @(posedge clk); #1 auto_en_a = 1'b1;
        for (int t = 0; t < 3; t++) begin pulse_tick_a(); repeat (5) @(posedge clk); end
        check("auto_clear_idx", {27'd0, disp_index_a}, 32'd6);
        push_a(5'd7, 32'h107);
        pulse_tick_a();
        drain(40);
        #1 auto_en_a = 1'b0;

        // freeze during WAIT: in-flight read still captures the new data, then holds
        push_a(5'd7, 32'h507);
        pulse_tick_a();
        freeze_a = 1'b1;
        base_a = 32'h500;
        drain(40);
        pulse_tick_a();
        repeat (5) @(posedge clk);
        press(1'b1, 1'b0, 1'b0);
        pulse_tick_a();
        repeat (10) @(posedge clk); #1;
        check("freeze_idx", {27'd0, disp_index_a}, 32'd7);
        check("freeze_val", disp_value_a, 32'h507);
        check("freeze_rd_addr", {27'd0, rd_addr_a}, 32'd7);

        // reset while a read is in WAIT: immediate return to reset values
        freeze_a = 1'b0;
        @(posedge clk); #1 btn_next_a = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 12 && !found; k++) begin
            @(posedge clk); #1;
            if (rd_addr_a != 5'd7) found = 1'b1;
        end
        check("rst_mid_step_seen", {31'd0, found}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", {31'd0, disp_valid_a}, 32'd0);
        check("rst_mid_value", disp_value_a, 32'd0);
        check("rst_mid_rd_addr", {27'd0, rd_addr_a}, 32'd5);
        check("rst_mid_index", {27'd0, disp_index_a}, 32'd5);
        check("rst_mid_b_valid", {31'd0, disp_valid_b}, 32'd0);
        btn_next_a = 1'b0;
        repeat (2) @(posedge clk); #1 rst_n = 1'b1;
        repeat (10) @(posedge clk); #1;
        check("post_rst_valid", {31'd0, disp_valid_a}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
